// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Width needed to hold 0 .. value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchronizer with a history flop; emits a one-cycle strobe per rising edge.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over GATE_CYCLES clk.
//   state      | meaning
//   ST_IDLE    | no gate running, waiting for en
//   ST_MEASURE | gate open, counting edges
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int               GW        = clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             edge_stb;
    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;
    logic             gate_last;

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sig_in),
        .rise (edge_stb)
    );

    // Overflow means an edge was actually dropped, so a count landing exactly on max is still exact.
    always_comb begin
        cnt_next = edge_cnt;
        sat_next = sat;
        if (edge_stb) begin
            if (edge_cnt == CNT_MAX) sat_next = 1'b1;
            else                     cnt_next = edge_cnt + 1'b1;
        end
    end

    assign gate_last = (gate_cnt == GATE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state    <= ST_MEASURE;
                        busy     <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (gate_last) begin
                        // Strobe in the last cycle belongs to this gate; next gate starts clean.
                        freq     <= cnt_next;
                        overflow <= sat_next;
                        valid    <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat      <= 1'b0;
                        if (!en) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        edge_cnt <= cnt_next;
                        sat      <= sat_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (8-bit and 4-bit counters) share stimulus; scoreboard per instance.
module tb_freq_meter;

    typedef struct {
        int lo;
        int hi;
        int ov;    // 0/1 expected overflow, 2 = don't care
        int mode;  // 0 none, 1 interval from previous valid, 2 interval from busy rise
    } item_t;

    logic       clk;
    logic       rst;
    logic       sig_in;
    logic       en;
    logic [7:0] freq8;
    logic       valid8, overflow8, busy8;
    logic [3:0] freq4;
    logic       valid4, overflow4, busy4;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    half     = 0;
    logic  level    = 1'b0;
    item_t q8[$];
    item_t q4[$];
    int    pbusy[2];
    int    rise_cyc[2];
    int    last_cyc[2];

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
        .freq(freq8), .valid(valid8), .overflow(overflow8), .busy(busy8)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
        .freq(freq4), .valid(valid4), .overflow(overflow4), .busy(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // sig_in generator: half==0 holds level, otherwise toggles every half clk.
    initial begin
        int cnt;
        cnt = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (half == 0) begin
                sig_in = level;
                cnt = 0;
            end else begin
                cnt = cnt + 1;
                if (cnt >= half) begin
                    sig_in = ~sig_in;
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected range %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic push(input int lo8, input int hi8, input int ov8,
                        input int lo4, input int hi4, input int ov4, input int mode);
        item_t it;
        it.lo = lo8; it.hi = hi8; it.ov = ov8; it.mode = mode;
        q8.push_back(it);
        it.lo = lo4; it.hi = hi4; it.ov = ov4;
        q4.push_back(it);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (q8.size() + q4.size()) != 0; i++) @(negedge clk);
        chk("drain_timeout", q8.size() + q4.size(), 0);
    endtask

    task automatic mon_dut(input int d, input logic bz, input logic vl, input int f, input int o);
        item_t it;
        string nm;
        int    sz;
        nm = (d == 0) ? "d8" : "d4";
        if (bz && pbusy[d] == 0) rise_cyc[d] = cyc;
        pbusy[d] = bz ? 1 : 0;
        if (vl) begin
            sz = (d == 0) ? q8.size() : q4.size();
            if (sz == 0) begin
                chk({nm, "_unexpected_valid"}, int'(vl), 0);
            end else begin
                it = (d == 0) ? q8.pop_front() : q4.pop_front();
                chk_range({nm, "_freq"}, f, it.lo, it.hi);
                if (it.ov != 2) chk({nm, "_overflow"}, o, it.ov);
                if (it.mode == 1) chk({nm, "_valid_period"}, cyc - last_cyc[d], 100);
                if (it.mode == 2) chk({nm, "_first_valid_latency"}, cyc - rise_cyc[d], 100);
            end
            last_cyc[d] = cyc;
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon_dut(0, busy8, valid8, int'(freq8), int'(overflow8));
        mon_dut(1, busy4, valid4, int'(freq4), int'(overflow4));
    end

    initial begin
        pbusy = '{0, 0};
        rise_cyc = '{0, 0};
        last_cyc = '{0, 0};
        rst = 1'b1;
        en  = 1'b0;
        half = 5;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_freq8", int'(freq8), 0);
        chk("reset_valid8", int'(valid8), 0);
        chk("reset_overflow8", int'(overflow8), 0);
        chk("reset_busy8", int'(busy8), 0);
        chk("reset_freq4", int'(freq4), 0);
        chk("reset_busy4", int'(busy4), 0);

        // Period 10, three back-to-back gates.
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_busy8", int'(busy8), 0);
        push(10, 10, 0, 10, 10, 0, 2);
        push(10, 10, 0, 10, 10, 0, 1);
        push(10, 10, 0, 10, 10, 0, 1);
        en = 1'b1;
        drain(400);

        // Held low, then held high.
        half = 0; level = 1'b0;
        push(0, 2, 0, 0, 2, 0, 1);
        push(0, 0, 0, 0, 0, 0, 1);
        drain(250);
        level = 1'b1;
        push(1, 1, 0, 1, 1, 0, 1);
        push(0, 0, 0, 0, 0, 0, 1);
        drain(250);

        // Period 4 (saturates the 4-bit instance), then period 20 switched mid-gate.
        half = 2;
        push(15, 26, 0, 15, 15, 2, 1);
        push(25, 25, 0, 15, 15, 1, 1);
        drain(250);
        push(5, 25, 0, 5, 15, 2, 1);
        push(5, 5, 0, 5, 5, 0, 1);
        repeat (50) @(negedge clk);
        half = 10;
        drain(250);

        // Abort at gate cycle 50: no valid, results hold.
        repeat (50) @(negedge clk);
        en = 1'b0;
        half = 5;
        @(posedge clk);
        #1;
        chk("abort_busy8", int'(busy8), 0);
        chk("abort_busy4", int'(busy4), 0);
        chk("abort_valid8", int'(valid8), 0);
        repeat (30) @(negedge clk);
        chk("abort_hold_freq8", int'(freq8), 5);
        chk("abort_hold_freq4", int'(freq4), 5);
        chk("abort_hold_overflow4", int'(overflow4), 0);
        push(10, 10, 0, 10, 10, 0, 2);
        en = 1'b1;
        drain(250);

        // Reset at gate cycle 30 of the following gate.
        repeat (30) @(negedge clk);
        rst = 1'b1;
        half = 0; level = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_freq8", int'(freq8), 0);
        chk("midrst_valid8", int'(valid8), 0);
        chk("midrst_overflow8", int'(overflow8), 0);
        chk("midrst_busy8", int'(busy8), 0);
        chk("midrst_freq4", int'(freq4), 0);
        repeat (2) @(negedge clk);
        push(10, 10, 0, 10, 10, 0, 2);
        push(10, 10, 0, 10, 10, 0, 1);
        rst = 1'b0;
        half = 5;
        drain(300);

        en = 1'b0;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
